row_fifo: RTL and testbench

ROW_FIFO -- requirements
Module: row_fifo

---
 rtl/row_fifo.sv | 63 ++++++
 tb/tb_row_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/row_fifo.sv
// row_fifo: first-word-fall-through FIFO of wide words with a sticky overflow flag.
// Define ROW_FIFO_LEVEL_EN to add the level_o occupancy output.
module row_fifo #(
    parameter int DEPTH      = 4,
    parameter int WORD_WIDTH = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [WORD_WIDTH-1:0]   data_i,
    input  logic                    data_valid_i,
    output logic [WORD_WIDTH-1:0]   data_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    overflow_o,
    input  logic                    overflow_clr_i
`ifdef ROW_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]  level_o
`endif
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] ONE = 1;
    localparam logic [PW:0] FULL = DEPTH[PW:0];
    logic [WORD_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          pop;
    logic          push;
    logic          drop;
    always_comb begin
        empty_o = count == '0;
        full_o  = count == FULL;
        valid_o = !empty_o;
        data_o  = mem[rd_ptr];
        pop     = valid_o && ready_i;
        push    = data_valid_i && (!full_o || pop);
        drop    = data_valid_i && !push;
    end
`ifdef ROW_FIFO_LEVEL_EN
    assign level_o = count;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push != pop) count <= push ? count + ONE : count - ONE;
            // a drop in the same cycle as a clear wins, so no drop goes unreported
            overflow_o <= drop || (overflow_o && !overflow_clr_i);
        end
    end
endmodule

// File: tb/tb_row_fifo.sv
// tb_row_fifo: vector table plus queue scoreboard for row_fifo (DEPTH=4, WORD_WIDTH=256).
module tb_row_fifo;
    localparam int DEPTH = 4;
    localparam int W = 256;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic data_valid_i = 1'b0;
    logic ready_i = 1'b0;
    logic overflow_clr_i = 1'b0;
    logic [W-1:0] data_i = '0;
    logic [W-1:0] data_o;
    logic valid_o, full_o, empty_o, overflow_o;
`ifdef ROW_FIFO_LEVEL_EN
    logic [2:0] level_o;
`endif
    int total = 0;
    int bad = 0;
    logic [W-1:0] sb[$];
    logic ovf_m = 1'b0;

    row_fifo #(.DEPTH(DEPTH), .WORD_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .data_i(data_i), .data_valid_i(data_valid_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .full_o(full_o),
        .empty_o(empty_o), .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i)
`ifdef ROW_FIFO_LEVEL_EN
        , .level_o(level_o)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] word(input int v);
        return {8{32'(v)}};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, score any pop against the queue, then check flags after the edge
    task automatic cycle(input bit p, input int v, input bit r, input bit c);
        bit pop_m, push_m;
        data_valid_i = p;
        data_i = word(v);
        ready_i = r;
        overflow_clr_i = c;
        pop_m = sb.size() > 0 && r;
        if (pop_m) check("pop_data", data_o, sb.pop_front());
        push_m = p && sb.size() < DEPTH;
        if (push_m) sb.push_back(word(v));
        ovf_m = (p && !push_m) || (ovf_m && !c);
        @(posedge clk);
        #1;
        data_valid_i = 1'b0;
        ready_i = 1'b0;
        overflow_clr_i = 1'b0;
        check("valid", W'(valid_o), W'(sb.size() > 0));
        check("empty", W'(empty_o), W'(sb.size() == 0));
        check("full", W'(full_o), W'(sb.size() == DEPTH));
        check("overflow", W'(overflow_o), W'(ovf_m));
        if (sb.size() > 0) check("head", data_o, sb[0]);
`ifdef ROW_FIFO_LEVEL_EN
        check("level", W'(level_o), W'(sb.size()));
`endif
    endtask

    task automatic do_reset(input bit p);
        rst_n = 1'b0;
        data_valid_i = p;
        data_i = word(99);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        data_valid_i = 1'b0;
        ready_i = 1'b0;
        sb.delete();
        ovf_m = 1'b0;
        check("rst_valid", W'(valid_o), W'(0));
        check("rst_empty", W'(empty_o), W'(1));
        check("rst_full", W'(full_o), W'(0));
        check("rst_overflow", W'(overflow_o), W'(0));
        check("rst_data", data_o, '0);
    endtask

    typedef struct {
        bit p; int v; bit r; bit c;
        bit ev; bit ef; bit eo; int eh;
    } vec_t;
    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 1, 0, 0, 1, 0, 0, 1};
        tbl[1] = '{1, 2, 0, 0, 1, 0, 0, 1};
        tbl[2] = '{1, 3, 0, 0, 1, 0, 0, 1};
        tbl[3] = '{1, 4, 0, 0, 1, 1, 0, 1};
        tbl[4] = '{1, 5, 0, 0, 1, 1, 1, 1};
        tbl[5] = '{0, 0, 1, 0, 1, 0, 1, 2};
        tbl[6] = '{0, 0, 1, 0, 1, 0, 1, 3};
        tbl[7] = '{0, 0, 1, 0, 1, 0, 1, 4};
        tbl[8] = '{0, 0, 1, 0, 0, 0, 1, 0};
        tbl[9] = '{0, 0, 0, 1, 0, 0, 0, 0};

        do_reset(1'b0);
        cycle(0, 0, 0, 0);
        check("idle_data", data_o, '0);

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].p, tbl[i].v, tbl[i].r, tbl[i].c);
            check($sformatf("tbl%0d_valid", i), W'(valid_o), W'(tbl[i].ev));
            check($sformatf("tbl%0d_full", i), W'(full_o), W'(tbl[i].ef));
            check($sformatf("tbl%0d_ovf", i), W'(overflow_o), W'(tbl[i].eo));
            if (tbl[i].ev) check($sformatf("tbl%0d_head", i), data_o, word(tbl[i].eh));
        end

        // full with pop and push together: accepted, stays full
        for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
        cycle(1, 5, 1, 0);
        check("fullpush_full", W'(full_o), W'(1));
        check("fullpush_ovf", W'(overflow_o), W'(0));
        check("fullpush_head", data_o, word(2));
        for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
        check("fullpush_empty", W'(empty_o), W'(1));

        // streaming through with ready held: one in flight, pointers wrap
        for (int i = 1; i <= 10; i++) begin
            cycle(1, i, 1, 0);
            check("stream_head", data_o, word(i));
        end
        cycle(0, 0, 1, 0);
        check("stream_empty", W'(empty_o), W'(1));

        // clear coinciding with a drop keeps the flag, clear alone drops it
        for (int i = 1; i <= 4; i++) cycle(1, 20 + i, 0, 0);
        cycle(1, 25, 0, 0);
        check("ovf_set", W'(overflow_o), W'(1));
        cycle(1, 26, 0, 1);
        check("ovf_clr_drop", W'(overflow_o), W'(1));
        cycle(0, 0, 0, 1);
        check("ovf_clr", W'(overflow_o), W'(0));
        cycle(0, 0, 1, 0);
        check("three_left_head", data_o, word(22));

        // reset with three stored and a coincident push
        do_reset(1'b1);
        cycle(0, 0, 1, 0);
        check("post_rst_valid", W'(valid_o), W'(0));
        cycle(1, 42, 0, 0);
        check("post_rst_push", data_o, word(42));
        cycle(0, 0, 1, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
